stump_mem_responder: RTL and testbench
======================================

Name: stump_mem_responder

Overview:
- Memory-side responder for the Stump processor memory interface. Services the fetch, load and store requests the control path issues via mem_ren/mem_wen.
- Holds a word-addressed 16-bit RAM and inserts a programmable number of wait states.
- Signals completion with a one-cycle mem_ready pulse.
- Sits between the Stump datapath address/data buses and on-chip storage; it is the target end of the processor's memory protocol.

Parameters:
ADDR_BITS, 8, number of implemented word-address bits; RAM depth = 2**ADDR_BITS words (1..15 legal)
WAIT_STATES, 1, extra cycles between request accept and mem_ready (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
mem_ren  input  1  read request from processor (fetch or load)
mem_wen  input  1  write request from processor (store)
address  input  16  word address
data_in  input  16  write data from processor
data_out  output  16  read data, registered
mem_ready  output  1  one-cycle pulse: access complete
mem_err  output  1  one-cycle pulse coincident with mem_ready: illegal access

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - data_out=16'h0000, mem_ready=0, mem_err=0.
  - FSM state IDLE, wait counter 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_ren|mem_wen, latch address, data_in and the op (read/write) at this edge.
  - Load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - Decrement counter each cycle; go to RESP when counter reaches 1.
  - If mem_ren and mem_wen are both low (request withdrawn), abort to IDLE: no write, no pulse.
- RESP (one cycle):
  - mem_ready=1.
  - Write: RAM[latched addr] <= latched data on this edge.
  - Read: data_out <= RAM[latched addr] on this edge, so data_out is valid when mem_ready is seen high.
  - Next state is IDLE.
- Latency: accept-to-mem_ready = WAIT_STATES+1 cycles. Back-to-back accesses: at most one accepted per WAIT_STATES+2 cycles.
- Handshake:
  - The processor holds mem_ren/mem_wen until mem_ready.
  - Address/data changes after accept are ignored (latched values used).
  - A request still asserted in IDLE after RESP is treated as a new access.
- data_out holds the last read value until the next completed read; writes never change it.
- Error cases (mem_err=1 with mem_ready):
  - mem_ren and mem_wen both high at accept: no RAM write, data_out unchanged.
  - address[15:ADDR_BITS] nonzero: write dropped; read returns data_out=16'h0000.
- Reset asserted mid-access:
  - FSM returns to IDLE immediately, no pulse.
  - A pending write is discarded, and RAM is not modified.
- Simultaneous withdraw and counter expiry in WAIT: withdraw wins (abort).

Optional Feature:
- Macro: STUMP_MEM_IO_EN.
- When defined:
  - Adds output port io_out[15:0], reset 16'h0000.
  - Address 16'hFFFF is a memory-mapped I/O register.
  - A write there updates io_out in RESP.
  - A read returns io_out.
  - This address does not raise mem_err and does not alias into RAM.
- When undefined: io_out does not exist, and 16'hFFFF is treated like any other address (out of range for ADDR_BITS<16, giving mem_err).

Test Plan:
1. Reset, WAIT_STATES=1: write 16'hBEEF to addr 16'h0010, hold wen → mem_ready high exactly 2 cycles after accept. Then read 16'h0010 → data_out=16'hBEEF with mem_ready, mem_err=0.
2. WAIT_STATES=0: continuous mem_ren at addr 16'h0000 holding 16'h1234 → mem_ready pulses every 2nd cycle, data_out=16'h1234 each time.
3. ADDR_BITS=8: read from 16'h0100 → mem_ready=1, mem_err=1, data_out=16'h0000. A write of 16'h5555 to 16'h0100 leaves RAM[16'h0000] unchanged.
4. mem_ren and mem_wen both high with data_in=16'hAAAA, addr 16'h0004 → mem_err pulse. A subsequent read of 16'h0004 returns the prior value.
5. WAIT_STATES=3: write request withdrawn after 1 wait cycle → no mem_ready, RAM unchanged. Separately, rst asserted during WAIT → outputs return to reset values asynchronously, and no write occurs.
6. STUMP_MEM_IO_EN defined: write 16'h00F0 to 16'hFFFF → io_out=16'h00F0, mem_err=0. A read of 16'hFFFF → data_out=16'h00F0.

Source files
------------

// File: rtl/stump_mem_responder.sv
// Memory-side responder for the Stump memory interface: word-addressed RAM, programmable wait states,
// one-cycle mem_ready/mem_err pulses. Define STUMP_MEM_IO_EN to add the io_out register at 16'hFFFF.
module stump_mem_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        mem_ready,
  output logic        mem_err
`ifdef STUMP_MEM_IO_EN
  ,
  output logic [15:0] io_out
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0]          wdata_q;
  logic                 wr_q, both_q, oor_q, io_hit_q;
  logic [15:0]          data_out_q, data_out_d;
  logic                 ready_q, ready_d, err_q, err_d;
  logic                 accept, ram_we;
  logic                 req, oor_in, io_in;
  logic [15:0]          io_rd;
  logic [15:0]          mem [Depth];

  assign req    = mem_ren | mem_wen;
  assign oor_in = (address >> ADDR_BITS) != 16'h0000;

`ifdef STUMP_MEM_IO_EN
  logic [15:0] io_q, io_d;
  assign io_in  = (address == 16'hFFFF);
  assign io_rd  = io_q;
  assign io_out = io_q;
`else
  assign io_in  = 1'b0;
  assign io_rd  = 16'h0000;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    ram_we     = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    data_out_d = data_out_q;
`ifdef STUMP_MEM_IO_EN
    io_d       = io_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        // A withdrawn request aborts even on the cycle the counter would expire.
        if (!req) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        ready_d = 1'b1;
        err_d   = both_q | oor_q;
        if (!both_q) begin
          if (wr_q) begin
            ram_we = !oor_q && !io_hit_q;
`ifdef STUMP_MEM_IO_EN
            if (io_hit_q) io_d = wdata_q;
`endif
          end else begin
            data_out_d = io_hit_q ? io_rd : (oor_q ? 16'h0000 : mem[idx_q]);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      wr_q       <= 1'b0;
      both_q     <= 1'b0;
      oor_q      <= 1'b0;
      io_hit_q   <= 1'b0;
      data_out_q <= 16'h0000;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      if (accept) begin
        idx_q    <= address[ADDR_BITS-1:0];
        wdata_q  <= data_in;
        wr_q     <= mem_wen & ~mem_ren;
        both_q   <= mem_wen & mem_ren;
        oor_q    <= oor_in & ~io_in;
        io_hit_q <= io_in;
      end
    end
  end

`ifdef STUMP_MEM_IO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) io_q <= 16'h0000;
    else     io_q <= io_d;
  end
`endif

  // RAM is deliberately not reset; state_q is, so a reset mid-access can never write.
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx_q] <= wdata_q;
  end

  assign data_out  = data_out_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Scoreboard bench for stump_mem_responder: three instances (WAIT_STATES 1, 0, 3) share one clock;
// a negedge monitor pops expected {data_out, mem_err} whenever an instance pulses mem_ready.
module tb_stump_mem_responder;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst  [3];
  logic        ren  [3];
  logic        wen  [3];
  logic [15:0] addr [3];
  logic [15:0] din  [3];
  logic [15:0] dout [3];
  logic        rdy  [3];
  logic        err  [3];
`ifdef STUMP_MEM_IO_EN
  logic [15:0] io   [3];
`endif

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  stump_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst[0]), .mem_ren(ren[0]), .mem_wen(wen[0]), .address(addr[0]),
    .data_in(din[0]), .data_out(dout[0]), .mem_ready(rdy[0]), .mem_err(err[0])
`ifdef STUMP_MEM_IO_EN
    , .io_out(io[0])
`endif
  );

  stump_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[1]), .mem_ren(ren[1]), .mem_wen(wen[1]), .address(addr[1]),
    .data_in(din[1]), .data_out(dout[1]), .mem_ready(rdy[1]), .mem_err(err[1])
`ifdef STUMP_MEM_IO_EN
    , .io_out(io[1])
`endif
  );

  stump_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[2]), .mem_ren(ren[2]), .mem_wen(wen[2]), .address(addr[2]),
    .data_in(din[2]), .data_out(dout[2]), .mem_ready(rdy[2]), .mem_err(err[2])
`ifdef STUMP_MEM_IO_EN
    , .io_out(io[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : ((d == 1) ? q1.size() : q2.size());
  endfunction

  task automatic push(input int d, input logic [15:0] data, input logic e);
    exp_t x;
    x.data = data;
    x.err  = e;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  // Monitor: every mem_ready pulse consumes one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rdy[d] === 1'b1) begin
          if (qsz(d) == 0) begin
            chk($sformatf("unexpected_ready_dut%0d", d), 32'(rdy[d]), 32'd0);
          end else begin
            case (d)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            chk($sformatf("data_out_dut%0d", d), 32'(dout[d]), 32'(e.data));
            chk($sformatf("mem_err_dut%0d", d), 32'(err[d]), 32'(e.err));
          end
        end
      end
    end
  end

  // One access held until mem_ready; address/data are scrambled after accept.
  task automatic access(input int d, input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] di, input logic [15:0] ed, input logic ee,
                        input string name);
    int n;
    logic seen;
    push(d, ed, ee);
    @(posedge clk);
    #1;
    ren[d] = r; wen[d] = w; addr[d] = a; din[d] = di;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[d] === 1'b1) seen = 1'b1;
      if (n == 2) begin
        addr[d] = a ^ 16'h0022;
        din[d]  = ~di;
      end
    end
    ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = 16'h0000; din[d] = 16'h0000;
    chk({name, "_latency"}, 32'(n), 32'(ws(d) + 3));
  endtask

  initial begin
    int n, pulses, last;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = 16'h0000; din[d] = 16'h0000;
    end
    #2;
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_data_out_%0d", d), 32'(dout[d]), 32'd0);
      chk($sformatf("reset_ready_%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset_err_%0d", d), 32'(err[d]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // WAIT_STATES=1: basic write/read, out-of-range, double request, I/O address.
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "t1_wr");
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "t1_rd");
    access(0, 1'b0, 1'b1, 16'h0000, 16'h9999, 16'hBEEF, 1'b0, "t3_wr0");
    access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, "t3_rd_oor");
    access(0, 1'b0, 1'b1, 16'h0100, 16'h5555, 16'h0000, 1'b1, "t3_wr_oor");
    access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h9999, 1'b0, "t3_rd0");
    access(0, 1'b0, 1'b1, 16'h0004, 16'h4444, 16'h9999, 1'b0, "t4_wr");
    access(0, 1'b1, 1'b1, 16'h0004, 16'hAAAA, 16'h9999, 1'b1, "t4_both");
    access(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h4444, 1'b0, "t4_rd");
`ifdef STUMP_MEM_IO_EN
    access(0, 1'b0, 1'b1, 16'hFFFF, 16'h00F0, 16'h4444, 1'b0, "t6_wr_io");
    chk("t6_io_out", 32'(io[0]), 32'h0000_00F0);
    access(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00F0, 1'b0, "t6_rd_io");
`else
    access(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, "t6_rd_ffff");
`endif

    // WAIT_STATES=0: held read completes every second cycle.
    access(1, 1'b0, 1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0, "t2_wr");
    for (int k = 0; k < 4; k++) push(1, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    ren[1] = 1'b1; addr[1] = 16'h0000;
    n = 0; pulses = 0; last = 0;
    while (pulses < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[1] === 1'b1) begin
        pulses++;
        if (pulses == 1) chk("t2_first_latency", 32'(n), 32'd3);
        else chk("t2_pulse_gap", 32'(n - last), 32'd2);
        last = n;
      end
    end
    ren[1] = 1'b0;
    chk("t2_pulse_count", 32'(pulses), 32'd4);

    // WAIT_STATES=3: withdrawn write and reset during WAIT must leave RAM alone.
    access(2, 1'b0, 1'b1, 16'h0005, 16'h7777, 16'h0000, 1'b0, "t5_wr");
    access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h7777, 1'b0, "t5_rd_a");
    @(posedge clk);
    #1;
    wen[2] = 1'b1; addr[2] = 16'h0005; din[2] = 16'h1111;
    repeat (2) @(negedge clk);
    wen[2] = 1'b0;
    repeat (8) @(negedge clk);
    access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h7777, 1'b0, "t5_rd_after_withdraw");
    @(posedge clk);
    #1;
    wen[2] = 1'b1; addr[2] = 16'h0005; din[2] = 16'h2222;
    repeat (2) @(negedge clk);
    #3;
    rst[2] = 1'b1;
    #1;
    chk("t5_rst_data_out", 32'(dout[2]), 32'd0);
    chk("t5_rst_ready", 32'(rdy[2]), 32'd0);
    chk("t5_rst_err", 32'(err[2]), 32'd0);
    wen[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    repeat (6) @(negedge clk);
    access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h7777, 1'b0, "t5_rd_after_rst");

    repeat (4) @(negedge clk);
    chk("pending_expectations", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
